// File: rtl/uparc_alu_mc_pkg.sv
// Shared opcode encodings and decode helpers for the uparc multi-cycle ALU.
// Opcode values keep the uparc_cpu_const.vh ordering, extended with the MDU ops.
package uparc_alu_mc_pkg;

   localparam int unsigned UPARC_ALUOP_WIDTH = 5;

   typedef logic [UPARC_ALUOP_WIDTH-1:0] aluop_t;

   localparam aluop_t UPARC_ALUOP_ADD   = 5'd0;
   localparam aluop_t UPARC_ALUOP_SUB   = 5'd1;
   localparam aluop_t UPARC_ALUOP_SLL   = 5'd2;
   localparam aluop_t UPARC_ALUOP_SRL   = 5'd3;
   localparam aluop_t UPARC_ALUOP_SRA   = 5'd4;
   localparam aluop_t UPARC_ALUOP_AND   = 5'd5;
   localparam aluop_t UPARC_ALUOP_OR    = 5'd6;
   localparam aluop_t UPARC_ALUOP_XOR   = 5'd7;
   localparam aluop_t UPARC_ALUOP_NOR   = 5'd8;
   localparam aluop_t UPARC_ALUOP_SLT   = 5'd9;
   localparam aluop_t UPARC_ALUOP_SLTU  = 5'd10;
   localparam aluop_t UPARC_ALUOP_MULT  = 5'd11;
   localparam aluop_t UPARC_ALUOP_MULTU = 5'd12;
   localparam aluop_t UPARC_ALUOP_DIV   = 5'd13;
   localparam aluop_t UPARC_ALUOP_DIVU  = 5'd14;
   localparam aluop_t UPARC_ALUOP_MFHI  = 5'd15;
   localparam aluop_t UPARC_ALUOP_MFLO  = 5'd16;

   typedef enum logic [1:0] {
      ITER_NONE = 2'd0,
      ITER_MUL  = 2'd1,
      ITER_DIV  = 2'd2
   } iter_kind_e;

   function automatic iter_kind_e iter_kind(input aluop_t op);
      case (op)
         UPARC_ALUOP_MULT, UPARC_ALUOP_MULTU: return ITER_MUL;
         UPARC_ALUOP_DIV,  UPARC_ALUOP_DIVU:  return ITER_DIV;
         default:                             return ITER_NONE;
      endcase
   endfunction

   function automatic logic op_signed(input aluop_t op);
      return (op == UPARC_ALUOP_MULT) || (op == UPARC_ALUOP_DIV);
   endfunction

endpackage

// File: rtl/uparc_mdu_iter.sv
// Iterative multiply/divide datapath: one product or quotient bit per clock,
// operating on magnitudes with the sign correction applied on the way out.
module uparc_mdu_iter
   import uparc_alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH = 32
)(
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_kill,
   input  logic             i_start,
   input  logic             i_div,
   input  logic             i_signed,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   // Upper half: partial product / remainder; lower half: multiplier / quotient.
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_a_raw;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_div;
   logic               r_neg_lo;
   logic               r_neg_hi;
   logic               r_dz;

   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_diff;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod_neg;
   logic [WIDTH-1:0]   w_quo_neg;
   logic [WIDTH-1:0]   w_rem_neg;

   assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // A borrow out of the trial subtraction means restore the shifted remainder.
   assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
   assign w_div_next  = w_div_diff[WIDTH]
                      ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

   assign w_prod_neg = -r_acc;
   assign w_quo_neg  = -r_acc[WIDTH-1:0];
   assign w_rem_neg  = -r_acc[2*WIDTH-1:WIDTH];

   assign o_last = (r_cnt == CNT_W'(1));

   always_comb begin
      o_hi = r_acc[2*WIDTH-1:WIDTH];
      o_lo = r_acc[WIDTH-1:0];
      if (r_dz) begin
         o_hi = r_a_raw;
         o_lo = '1;
      end else if (r_div) begin
         if (r_neg_lo) o_lo = w_quo_neg;
         if (r_neg_hi) o_hi = w_rem_neg;
      end else if (r_neg_lo) begin
         o_hi = w_prod_neg[2*WIDTH-1:WIDTH];
         o_lo = w_prod_neg[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_acc    <= '0;
         r_opnd   <= '0;
         r_a_raw  <= '0;
         r_cnt    <= '0;
         r_div    <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_dz     <= 1'b0;
      end else if (i_kill) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_acc    <= i_div ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
         r_opnd   <= i_div ? w_b_mag : w_a_mag;
         r_a_raw  <= i_a;
         r_cnt    <= CNT_W'(WIDTH);
         r_div    <= i_div;
         r_neg_lo <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         r_neg_hi <= i_signed && i_div && i_a[WIDTH-1];
         r_dz     <= i_div && (i_b == '0);
      end else if (i_step) begin
         r_acc <= r_div ? w_div_next : w_mul_next;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/uparc_alu_mc.sv
// uparc execute-stage ALU: registered single-cycle ops plus an iterative
// MULT/DIV unit writing HI/LO, with valid/ready issue and kill flush.
module uparc_alu_mc
   import uparc_alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
)(
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         i_valid,
   input  logic [UPARC_ALUOP_WIDTH-1:0] i_op,
   input  logic [WIDTH-1:0]             i_a,
   input  logic [WIDTH-1:0]             i_b,
   input  logic                         i_kill,
   output logic                         o_ready,
   output logic                         o_valid,
   output logic [WIDTH-1:0]             o_result,
   output logic                         o_ovflow
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_SIGN = 2'd3;

   logic [1:0]       r_state;
   logic             r_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_ovflow;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_accept;
   logic             w_start;
   logic             w_step;
   logic             w_last;
   iter_kind_e       w_kind;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_sum_ov;
   logic             w_diff_ov;
   logic [WIDTH-1:0] w_alu;
   logic             w_alu_ov;
   logic [WIDTH-1:0] w_fix_hi;
   logic [WIDTH-1:0] w_fix_lo;

   assign o_ready  = (r_state == ST_IDLE) && nrst;
   assign o_valid  = r_valid;
   assign o_result = r_result;
   assign o_ovflow = r_ovflow;

   assign w_accept = i_valid && o_ready && !i_kill;
   assign w_kind   = iter_kind(i_op);
   assign w_start  = w_accept && (w_kind != ITER_NONE);
   assign w_step   = ((r_state == ST_MUL) || (r_state == ST_DIV)) && !i_kill;

   assign w_sum     = i_a + i_b;
   assign w_diff    = i_a + ~i_b + WIDTH'(1);
   assign w_sum_ov  = (i_a[WIDTH-1] == i_b[WIDTH-1])  && (w_sum[WIDTH-1]  != i_a[WIDTH-1]);
   assign w_diff_ov = (i_a[WIDTH-1] == ~i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);

   always_comb begin
      w_alu    = '0;
      w_alu_ov = 1'b0;
      case (i_op)
         UPARC_ALUOP_ADD:  begin w_alu = w_sum;  w_alu_ov = w_sum_ov;  end
         UPARC_ALUOP_SUB:  begin w_alu = w_diff; w_alu_ov = w_diff_ov; end
         UPARC_ALUOP_SLL:  w_alu = i_a << i_b[SHAMT_W-1:0];
         UPARC_ALUOP_SRL:  w_alu = i_a >> i_b[SHAMT_W-1:0];
         UPARC_ALUOP_SRA:  w_alu = $unsigned($signed(i_a) >>> i_b[SHAMT_W-1:0]);
         UPARC_ALUOP_AND:  w_alu = i_a & i_b;
         UPARC_ALUOP_OR:   w_alu = i_a | i_b;
         UPARC_ALUOP_XOR:  w_alu = i_a ^ i_b;
         UPARC_ALUOP_NOR:  w_alu = ~(i_a | i_b);
         UPARC_ALUOP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         UPARC_ALUOP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
         UPARC_ALUOP_MFHI: w_alu = r_hi;
         UPARC_ALUOP_MFLO: w_alu = r_lo;
         default:          w_alu = '0;
      endcase
   end

   uparc_mdu_iter #(
      .WIDTH (WIDTH)
   ) u_mdu (
      .clk      (clk),
      .nrst     (nrst),
      .i_kill   (i_kill),
      .i_start  (w_start),
      .i_div    (w_kind == ITER_DIV),
      .i_signed (op_signed(i_op)),
      .i_step   (w_step),
      .i_a      (i_a),
      .i_b      (i_b),
      .o_last   (w_last),
      .o_hi     (w_fix_hi),
      .o_lo     (w_fix_lo)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state  <= ST_IDLE;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_ovflow <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (i_kill) begin
         r_state  <= ST_IDLE;
         r_valid  <= 1'b0;
         r_ovflow <= 1'b0;
      end else begin
         r_valid  <= 1'b0;
         r_ovflow <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (w_kind)
                     ITER_MUL: r_state <= ST_MUL;
                     ITER_DIV: r_state <= ST_DIV;
                     default: begin
                        r_valid  <= 1'b1;
                        r_result <= w_alu;
                        r_ovflow <= w_alu_ov;
                     end
                  endcase
               end
            end
            ST_MUL, ST_DIV: begin
               if (w_last) r_state <= ST_SIGN;
            end
            ST_SIGN: begin
               r_hi     <= w_fix_hi;
               r_lo     <= w_fix_lo;
               r_result <= w_fix_lo;
               r_valid  <= 1'b1;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uparc_alu_mc.sv
// Scoreboard bench for uparc_alu_mc: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_uparc_alu_mc;
   import uparc_alu_mc_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         nrst;
   logic         i_valid;
   aluop_t       i_op;
   logic [W-1:0] i_a;
   logic [W-1:0] i_b;
   logic         i_kill;
   logic         o_ready;
   logic         o_valid;
   logic [W-1:0] o_result;
   logic         o_ovflow;

   uparc_alu_mc #(.WIDTH(W)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .i_valid  (i_valid),
      .i_op     (i_op),
      .i_a      (i_a),
      .i_b      (i_b),
      .i_kill   (i_kill),
      .o_ready  (o_ready),
      .o_valid  (o_valid),
      .o_result (o_result),
      .o_ovflow (o_ovflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      aluop_t       op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ov;
   } exp_t;

   exp_t         sb_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   // Reference: 64-bit integer arithmetic; updates the model HI/LO.
   function automatic void model(input aluop_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] res, output logic ov);
      longint      sa, sb, s, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = '0;
      ov  = 1'b0;
      case (op)
         UPARC_ALUOP_ADD:  begin s = sa + sb; res = s[31:0]; ov = (s != longint'($signed(res))); end
         UPARC_ALUOP_SUB:  begin s = sa - sb; res = s[31:0]; ov = (s != longint'($signed(res))); end
         UPARC_ALUOP_SLL:  res = a << b[4:0];
         UPARC_ALUOP_SRL:  res = a >> b[4:0];
         UPARC_ALUOP_SRA:  begin s = sa >>> b[4:0]; res = s[31:0]; end
         UPARC_ALUOP_AND:  res = a & b;
         UPARC_ALUOP_OR:   res = a | b;
         UPARC_ALUOP_XOR:  res = a ^ b;
         UPARC_ALUOP_NOR:  res = ~(a | b);
         UPARC_ALUOP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
         UPARC_ALUOP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
         UPARC_ALUOP_MULT: begin s = sa * sb; m_hi = s[63:32]; m_lo = s[31:0]; res = m_lo; end
         UPARC_ALUOP_MULTU: begin
            p = {32'b0, a} * {32'b0, b};
            m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo;
         end
         UPARC_ALUOP_DIV: begin
            if (b == '0) begin m_hi = a; m_lo = '1; end
            else begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
            res = m_lo;
         end
         UPARC_ALUOP_DIVU: begin
            if (b == '0) begin m_hi = a; m_lo = '1; end
            else begin m_hi = a % b; m_lo = a / b; end
            res = m_lo;
         end
         UPARC_ALUOP_MFHI: res = m_hi;
         UPARC_ALUOP_MFLO: res = m_lo;
         default:          res = '0;
      endcase
   endfunction

   function automatic logic [W-1:0] rnd();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 40));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every result strobe pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (nrst === 1'b1 && o_valid === 1'b1) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: result %h with no outstanding op", o_result);
         end else begin
            e = sb_q.pop_front();
            if (o_result !== e.res || o_ovflow !== e.ov) begin
               n_fail++;
               $display("FAIL scoreboard op=%0d a=%h b=%h: got result %h ovflow %b, expected %h ovflow %b",
                        e.op, e.a, e.b, o_result, o_ovflow, e.res, e.ov);
            end
         end
      end
   end

   // Drives a request and returns #1 after the edge that sampled it.
   task automatic issue(input aluop_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit expect_result);
      int   n = 0;
      exp_t e;
      i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
      while (o_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (o_ready !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL issue_timeout op=%0d: o_ready %b, expected 1", op, o_ready);
         i_valid = 1'b0;
         return;
      end
      if (expect_result) begin
         e.op = op; e.a = a; e.b = b;
         model(op, a, b, e.res, e.ov);
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic issue_chk(input string name, input aluop_t op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp);
      issue(op, a, b, 1'b1);
      check(name, o_result, exp);
   endtask

   task automatic idle();
      i_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int     lat, rdy_low;
      aluop_t op;

      nrst = 1'b0; i_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0; i_kill = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid",  W'(o_valid),  32'd0);
      check("reset_result", o_result,     32'd0);
      check("reset_ovflow", W'(o_ovflow), 32'd0);
      check("reset_ready",  W'(o_ready),  32'd0);
      nrst = 1'b1;
      #1;
      check("ready_after_reset", W'(o_ready), 32'd1);

      // Single-cycle ops, back to back.
      issue(UPARC_ALUOP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
      check("add_valid",  W'(o_valid),  32'd1);
      check("add_result", o_result,     32'h8000_0000);
      check("add_ovflow", W'(o_ovflow), 32'd1);
      issue_chk("sub_result", UPARC_ALUOP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
      check("sub_ovflow", W'(o_ovflow), 32'd0);
      check("b2b_ready",  W'(o_ready),  32'd1);
      issue_chk("nor",  UPARC_ALUOP_NOR,  32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0);
      issue_chk("sra",  UPARC_ALUOP_SRA,  32'h8000_0000, 32'd36,        32'hF800_0000);
      issue_chk("sltu", UPARC_ALUOP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1);
      issue_chk("slt",  UPARC_ALUOP_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0);
      issue_chk("unknown_op", aluop_t'(5'd25), 32'h1234, 32'h5678, 32'd0);
      idle();

      // MULT latency and HI/LO readback on the completion cycle.
      issue(UPARC_ALUOP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
      idle();
      lat = 0; rdy_low = 0;
      while (o_valid !== 1'b1 && lat < 100) begin
         if (o_ready === 1'b0) rdy_low++;
         @(posedge clk); #1; lat++;
      end
      check("mult_latency",   W'(lat),     32'd33);
      check("mult_ready_low", W'(rdy_low), 32'd33);
      check("mult_result",    o_result,    32'hFFFF_FFEB);
      check("mult_ready_end", W'(o_ready), 32'd1);
      issue_chk("mult_mfhi", UPARC_ALUOP_MFHI, '0, '0, 32'hFFFF_FFFF);
      issue_chk("mult_mflo", UPARC_ALUOP_MFLO, '0, '0, 32'hFFFF_FFEB);

      issue(UPARC_ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
      issue_chk("div_mflo", UPARC_ALUOP_MFLO, '0, '0, 32'hFFFF_FFFD);
      issue_chk("div_mfhi", UPARC_ALUOP_MFHI, '0, '0, 32'hFFFF_FFFF);
      issue(UPARC_ALUOP_DIVU, 32'd7, 32'd0, 1'b1);
      issue_chk("divz_mflo", UPARC_ALUOP_MFLO, '0, '0, 32'hFFFF_FFFF);
      issue_chk("divz_mfhi", UPARC_ALUOP_MFHI, '0, '0, 32'h0000_0007);
      idle();

      // Kill mid-divide, then kill with a request pending in IDLE.
      issue(UPARC_ALUOP_DIVU, 32'd100, 32'd3, 1'b0);
      idle();
      repeat (10) @(posedge clk);
      #1;
      i_kill = 1'b1;
      @(posedge clk); #1;
      i_kill = 1'b0;
      check("kill_ready", W'(o_ready), 32'd1);
      check("kill_valid", W'(o_valid), 32'd0);
      i_kill = 1'b1;
      issue(UPARC_ALUOP_ADD, 32'd1, 32'd2, 1'b0);
      i_kill = 1'b0;
      idle();
      check("kill_idle_valid", W'(o_valid), 32'd0);
      issue_chk("kill_mfhi", UPARC_ALUOP_MFHI, '0, '0, 32'h0000_0007);
      issue_chk("kill_mflo", UPARC_ALUOP_MFLO, '0, '0, 32'hFFFF_FFFF);
      issue_chk("kill_add",  UPARC_ALUOP_ADD, 32'd2, 32'd3, 32'd5);

      // Reset in the middle of a MULT.
      issue(UPARC_ALUOP_MULT, 32'd12345, 32'd678, 1'b0);
      idle();
      repeat (5) @(posedge clk);
      #1;
      nrst = 1'b0;
      @(posedge clk); #1;
      check("midrst_valid",  W'(o_valid),  32'd0);
      check("midrst_result", o_result,     32'd0);
      check("midrst_ovflow", W'(o_ovflow), 32'd0);
      check("midrst_ready",  W'(o_ready),  32'd0);
      m_hi = '0; m_lo = '0;
      nrst = 1'b1;
      #1;
      check("midrst_ready_release", W'(o_ready), 32'd1);
      issue_chk("midrst_mfhi", UPARC_ALUOP_MFHI, '0, '0, 32'd0);
      issue_chk("midrst_mflo", UPARC_ALUOP_MFLO, '0, '0, 32'd0);

      // Random mix including iterative ops, MFHI/MFLO and unknown opcodes.
      for (int k = 0; k < 300; k++) begin
         op = aluop_t'($urandom_range(0, 20));
         issue(op, rnd(), rnd(), 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
         end
      end
      idle();
      repeat (40) @(posedge clk);
      #1;
      check("queue_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
